// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM of the multi-cycle RV32I core
// Optional MEM_HANDSHAKE_EN adds mem_ready and stalls FETCH/MEMREAD/MEMWRITE until it is high.
module multicycle_main_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       Zero,
`ifdef MEM_HANDSHAKE_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11,
        S_JALWB    = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   rdy;
    logic   pc_update, branch, ir_c, mw_c, rw_c, done_c, halt_c;

`ifdef MEM_HANDSHAKE_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_c      = 1'b0;
        mw_c      = 1'b0;
        rw_c      = 1'b0;
        done_c    = 1'b0;
        halt_c    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                ir_c      = rdy;
                pc_update = rdy;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BEQ;
                    7'b1101111:             state_d = S_JAL;
                    default:                state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rw_c      = 1'b1;
                done_c    = 1'b1;
            end
            // MemWrite is held across stall cycles; retirement waits for ready
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mw_c    = 1'b1;
                done_c  = rdy;
                state_d = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c   = 1'b1;
                done_c = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                done_c  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                done_c    = 1'b1;
                state_d   = S_JALWB;
            end
            // Writeback of rd = PC+4 after jal; the instruction already retired in JAL
            S_JALWB: rw_c = 1'b1;
            S_HALT: begin
                halt_c  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    // Reset gates the write enables so no partial write follows the falling edge of rst_n
    assign PCWrite    = rst_n & (pc_update | (branch & Zero));
    assign IRWrite    = rst_n & ir_c;
    assign MemWrite   = rst_n & mw_c;
    assign RegWrite   = rst_n & rw_c;
    assign instr_done = rst_n & done_c;
    assign halted     = rst_n & halt_c;

endmodule
